// File: rtl/bus_reg_bank.sv
// bus_reg_bank: small bank of bus-mapped registers (RW, RO or W1C status) with an
// IRQ-enable register and a registered interrupt output.
//
// bus_in layout (68 bits):
//   [67] bus_clk, [66] bus_reset_l, [65] wr_req, [64] rd_req,
//   [63:32] wr_data, [31:0] addr
// bus_out layout (35 bits):
//   [34] irq, [33] wr_ack, [32] rd_ack, [31:0] rd_data
module bus_reg_bank #(
  parameter int unsigned          NREGS     = 4,
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [31:0]          BUS_ADDR  = 32'h0,
  parameter logic [DATAWIDTH-1:0] IZ        = '0,
  parameter logic [NREGS-1:0]     RO_MASK   = '0,
  parameter logic [NREGS-1:0]     W1C_MASK  = '0,
  localparam int unsigned         BUS_IN_WIDTH  = 68,
  localparam int unsigned         BUS_OUT_WIDTH = 35
) (
  input  logic [BUS_IN_WIDTH-1:0]    bus_in,
  output logic [BUS_OUT_WIDTH-1:0]   bus_out,
  input  logic [NREGS*DATAWIDTH-1:0] in,
  input  logic [NREGS*DATAWIDTH-1:0] set,
  output logic [NREGS*DATAWIDTH-1:0] out,
  output logic [NREGS-1:0]           rd_pulse,
  output logic [NREGS-1:0]           wr_pulse,
  output logic                       irq
);

  // RO wins over W1C when both mask bits are set.
  localparam logic [NREGS-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;

  logic        bus_clk;
  logic        bus_reset_l;
  logic        w_wr_req;
  logic        w_rd_req;
  logic [31:0] w_wr_data;
  logic [31:0] w_addr;
  logic [31:0] w_addr_al;

  assign bus_clk     = bus_in[67];
  assign bus_reset_l = bus_in[66];
  assign w_wr_req    = bus_in[65];
  assign w_rd_req    = bus_in[64];
  assign w_wr_data   = bus_in[63:32];
  assign w_addr      = bus_in[31:0];
  assign w_addr_al   = {w_addr[31:2], 2'b00};

  // Byte-lane bits of the address and unused upper data/in/set bits are folded here.
  logic w_unused;
  assign w_unused = ^{w_addr[1:0], w_wr_data, in, set};

  logic [DATAWIDTH-1:0] r_regs [NREGS];
  logic [DATAWIDTH-1:0] w_regs_d [NREGS];
  logic [DATAWIDTH-1:0] w_clr;
  logic [NREGS-1:0]     r_irq_en;
  logic [NREGS-1:0]     w_irq_en_d;
  logic [NREGS-1:0]     w_hit;
  logic                 w_hit_en;
  logic                 w_any_hit;
  logic [NREGS-1:0]     w_nonzero;
  logic [31:0]          w_rd_data;
  logic                 w_irq_d;

  logic                 r_rd_ack;
  logic                 r_wr_ack;
  logic [31:0]          r_rd_data;
  logic [NREGS-1:0]     r_rd_pulse;
  logic [NREGS-1:0]     r_wr_pulse;
  logic                 r_irq;

  // Address decode against each data register and the IRQ-enable register.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_hit[i] = (w_addr_al == BUS_ADDR + 32'(4 * i));
    end
    w_hit_en  = (w_addr_al == BUS_ADDR + 32'(4 * NREGS));
    w_any_hit = (|w_hit) | w_hit_en;
  end

  // Read mux: RO registers return the live hardware input, others the stored value.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (w_hit[i]) begin
        if (RO_MASK[i]) begin
          w_rd_data[DATAWIDTH-1:0] = in[i*DATAWIDTH +: DATAWIDTH];
        end else begin
          w_rd_data[DATAWIDTH-1:0] = r_regs[i];
        end
      end
    end
    if (w_hit_en) begin
      w_rd_data[NREGS-1:0] = r_irq_en;
    end
  end

  // Register next state: RW load, W1C clear-then-set, RO storage tied to zero.
  always_comb begin
    w_clr = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_regs_d[i] = r_regs[i];
      w_clr       = '0;
      if (RO_MASK[i]) begin
        w_regs_d[i] = '0;
      end else if (W1C_EFF[i]) begin
        if (w_wr_req && w_hit[i]) begin
          w_clr = w_wr_data[DATAWIDTH-1:0];
        end
        // OR-ing set last makes a same-cycle set win over clear.
        w_regs_d[i] = (r_regs[i] & ~w_clr) | set[i*DATAWIDTH +: DATAWIDTH];
      end else if (w_wr_req && w_hit[i]) begin
        w_regs_d[i] = w_wr_data[DATAWIDTH-1:0];
      end
    end
    if (w_wr_req && w_hit_en) begin
      w_irq_en_d = w_wr_data[NREGS-1:0] & W1C_EFF;
    end else begin
      w_irq_en_d = r_irq_en;
    end
  end

  // Interrupt source: any enabled, non-empty status register.
  always_comb begin
    w_nonzero = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_nonzero[i] = |r_regs[i];
    end
    w_irq_d = |(W1C_EFF & r_irq_en & w_nonzero);
  end

  // State, acks, pulses and irq; reset drops any request in flight.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= (RO_MASK[i] || W1C_EFF[i]) ? '0 : IZ;
      end
      r_irq_en   <= '0;
      r_rd_ack   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_pulse <= '0;
      r_wr_pulse <= '0;
      r_irq      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= w_regs_d[i];
      end
      r_irq_en   <= w_irq_en_d;
      r_rd_ack   <= w_rd_req & w_any_hit;
      r_wr_ack   <= w_wr_req & w_any_hit;
      r_rd_data  <= w_rd_req ? w_rd_data : '0;
      r_rd_pulse <= w_rd_req ? w_hit : '0;
      r_wr_pulse <= w_wr_req ? w_hit : '0;
      r_irq      <= w_irq_d;
    end
  end

  // Output packing; RO slices of out read as zero.
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      out[i*DATAWIDTH +: DATAWIDTH] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign bus_out  = {r_irq, r_wr_ack, r_rd_ack, r_rd_data};
  assign rd_pulse = r_rd_pulse;
  assign wr_pulse = r_wr_pulse;
  assign irq      = r_irq;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed self-checking bench for bus_reg_bank (NREGS=4, 16-bit regs, base 0x100,
// reg1 read-only, reg3 write-1-to-clear status).
module tb_bus_reg_bank;

  localparam logic [31:0] BASE = 32'h100;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [63:0] tb_in;
  logic [63:0] tb_set;

  logic [67:0] bus_in;
  logic [34:0] bus_out;
  logic [63:0] out;
  logic [3:0]  rd_pulse;
  logic [3:0]  wr_pulse;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  assign bus_in = {clk, rst_n, wr_req, rd_req, wdata, addr};

  bus_reg_bank #(
    .NREGS    (4),
    .DATAWIDTH(16),
    .BUS_ADDR (BASE),
    .IZ       (16'h0005),
    .RO_MASK  (4'b0010),
    .W1C_MASK (4'b1000)
  ) u_dut (
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .in      (tb_in),
    .set     (tb_set),
    .out     (out),
    .rd_pulse(rd_pulse),
    .wr_pulse(wr_pulse),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request: driven at negedge, sampled at posedge, outputs checked 1ns after that edge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    rd_req = rd;
    wr_req = wr;
    addr   = a;
    wdata  = d;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_addr [5];
  logic [31:0] b2b_exp  [5];

  initial begin
    rst_n  = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    wdata  = '0;
    addr   = '0;
    tb_in  = '0;
    tb_set = '0;

    // Set pulses during reset must be ignored.
    tb_set[63:48] = 16'hFFFF;
    repeat (3) idle_cycle();
    check("reset_bus_out", 64'(bus_out), 64'h0);
    check("reset_out", out, 64'h0000_0005_0000_0005);
    check("reset_pulses", 64'({rd_pulse, wr_pulse, irq}), 64'h0);
    tb_set = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Read reg0 after reset: IZ value.
    do_req(1'b1, 1'b0, BASE, 32'h0);
    check("rd0_ack", 64'({bus_out[33], bus_out[32]}), 64'b01);
    check("rd0_data", 64'(bus_out[31:0]), 64'h5);
    check("rd0_pulse", 64'(rd_pulse), 64'b0001);
    idle_cycle();
    check("rd0_ack_gone", 64'(bus_out[32:0]), 64'h0);

    // RW write and read-back of reg2.
    do_req(1'b0, 1'b1, BASE + 32'h8, 32'h0000_A5A5);
    check("wr2_ack", 64'({bus_out[33], bus_out[32]}), 64'b10);
    check("wr2_pulse", 64'(wr_pulse), 64'b0100);
    check("wr2_out", 64'(out[47:32]), 64'hA5A5);
    do_req(1'b1, 1'b0, BASE + 32'h8, 32'h0);
    check("rd2_data", 64'(bus_out[31:0]), 64'hA5A5);

    // Write data wider than the register is truncated; read data zero-extended.
    do_req(1'b0, 1'b1, BASE, 32'hFFFF_C3C3);
    do_req(1'b1, 1'b0, BASE, 32'h0);
    check("rd0_trunc", 64'(bus_out[31:0]), 64'h0000_C3C3);

    // Simultaneous read and write: both ack, read returns pre-write value.
    do_req(1'b1, 1'b1, BASE + 32'h8, 32'h0000_5A5A);
    check("rw2_acks", 64'({bus_out[33], bus_out[32]}), 64'b11);
    check("rw2_data", 64'(bus_out[31:0]), 64'hA5A5);
    check("rw2_pulses", 64'({rd_pulse, wr_pulse}), 64'h44);
    do_req(1'b1, 1'b0, BASE + 32'h8, 32'h0);
    check("rd2_after_rw", 64'(bus_out[31:0]), 64'h5A5A);

    // Unaligned address decodes to the word.
    do_req(1'b1, 1'b0, BASE + 32'h9, 32'h0);
    check("rd2_unaligned", 64'(bus_out[32:0]), 64'h1_0000_5A5A);

    // RO register: write acked and ignored, read returns hardware input.
    tb_in[31:16] = 16'h1234;
    do_req(1'b0, 1'b1, BASE + 32'h4, 32'h0000_FFFF);
    check("wr1_ro_ack", 64'({bus_out[33], wr_pulse}), 64'b1_0010);
    do_req(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    check("rd1_ro_data", 64'(bus_out[31:0]), 64'h1234);
    check("ro_out_zero", 64'(out[31:16]), 64'h0);

    // IRQ enable: only the W1C bit is writable.
    do_req(1'b0, 1'b1, BASE + 32'h10, 32'h0000_000F);
    do_req(1'b1, 1'b0, BASE + 32'h10, 32'h0);
    check("irq_en_rd", 64'(bus_out[31:0]), 64'h8);
    check("irq_idle", 64'(irq), 64'h0);

    // Status set pulse -> irq one cycle after the status changes.
    @(negedge clk);
    tb_set[63:48] = 16'h0003;
    @(posedge clk);
    #1;
    tb_set = '0;
    check("w1c_set_val", 64'(out[63:48]), 64'h3);
    check("irq_not_yet", 64'(irq), 64'h0);
    idle_cycle();
    check("irq_raised", 64'({irq, bus_out[34]}), 64'b11);

    // Write-1-to-clear bit 0.
    do_req(1'b0, 1'b1, BASE + 32'hC, 32'h1);
    check("w1c_clr_val", 64'(out[63:48]), 64'h2);
    idle_cycle();
    check("irq_still", 64'(irq), 64'h1);

    // Clear and set of the same bit in the same cycle: set wins.
    @(negedge clk);
    wr_req        = 1'b1;
    addr          = BASE + 32'hC;
    wdata         = 32'h2;
    tb_set[63:48] = 16'h0002;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    tb_set = '0;
    check("w1c_set_wins", 64'(out[63:48]), 64'h2);

    // Clear fully -> irq drops one cycle later.
    do_req(1'b0, 1'b1, BASE + 32'hC, 32'h2);
    check("w1c_cleared", 64'(out[63:48]), 64'h0);
    idle_cycle();
    check("irq_dropped", 64'(irq), 64'h0);

    // Back-to-back reads every cycle, each acked one cycle later.
    b2b_addr = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10};
    b2b_exp  = '{32'hC3C3, 32'h1234, 32'h5A5A, 32'h0, 32'h8};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd_req = 1'b1;
      addr   = b2b_addr[i];
      @(posedge clk);
      #1;
      check($sformatf("b2b_%0d", i), 64'(bus_out[32:0]), {31'h0, 1'b1, b2b_exp[i]});
    end
    rd_req = 1'b0;

    // Unmapped addresses: no ack, zero data.
    do_req(1'b1, 1'b1, BASE + 32'h14, 32'hFFFF_FFFF);
    check("unmapped_hi", 64'({bus_out, rd_pulse, wr_pulse}), 64'h0);
    do_req(1'b1, 1'b0, BASE - 32'h4, 32'h0);
    check("unmapped_lo", 64'(bus_out), 64'h0);

    // Raise irq, then reset with a read in flight.
    @(negedge clk);
    tb_set[63:48] = 16'h0001;
    @(posedge clk);
    #1;
    tb_set = '0;
    idle_cycle();
    check("irq_before_rst", 64'(irq), 64'h1);
    @(negedge clk);
    rd_req = 1'b1;
    addr   = BASE;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out", out, 64'h0000_0005_0000_0005);
    check("rst_async_irq", 64'(irq), 64'h0);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check("rst_inflight", 64'({bus_out, rd_pulse, wr_pulse}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    check("no_ack_after_rel", 64'(bus_out), 64'h0);

    // First request after release served normally; irq_en was cleared.
    do_req(1'b1, 1'b0, BASE + 32'h8, 32'h0);
    check("post_rst_rd2", 64'(bus_out[32:0]), 64'h1_0000_0005);
    do_req(1'b1, 1'b0, BASE + 32'h10, 32'h0);
    check("post_rst_irq_en", 64'(bus_out[32:0]), 64'h1_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_reg_bank.md
BUS_REG_BANK -- requirements
Module: bus_reg_bank

Interface
REQ-001 SHALL have parameter NREGS, default 4, number of data registers (1..8) at consecutive word addresses.
REQ-002 SHALL have parameter DATAWIDTH, default 32, bits per register (1..32), read data zero-extended to bus width.
REQ-003 SHALL have parameter BUS_ADDR, default 0, word-aligned base address; register i at BUS_ADDR+4*i, IRQ-enable register at BUS_ADDR+4*NREGS.
REQ-004 SHALL have parameter IZ, default 0, reset value of every RW register.
REQ-005 SHALL have parameter RO_MASK, default 0, NREGS bits; bit i=1 makes register i read-only (reads in[i]).
REQ-006 SHALL have parameter W1C_MASK, default 0, NREGS bits; bit i=1 makes register i a status register (hw set, sw write-1-to-clear); RO_MASK takes precedence if both set.
REQ-007 SHALL have bus_clk  input  1  sole clock, carried in bus_in.
REQ-008 SHALL have bus_reset_l  input  1  asynchronous active-low reset, carried in bus_in.
REQ-009 SHALL have bus_in  input  BUS_IN_WIDTH  bus request (addr, wr_data, rd_req, wr_req, clock, reset).
REQ-010 SHALL have bus_out  output  BUS_OUT_WIDTH  rd_data, rd_ack, wr_ack, irq.
REQ-011 SHALL have in  input  NREGS*DATAWIDTH  hardware values for RO registers, slice i = [i*DATAWIDTH +: DATAWIDTH].
REQ-012 SHALL have set  input  NREGS*DATAWIDTH  per-bit set pulses for W1C registers.
REQ-013 SHALL have out  output  NREGS*DATAWIDTH  current register contents (RO slices drive 0).
REQ-014 SHALL have rd_pulse  output  NREGS  one-cycle pulse per register read.
REQ-015 SHALL have wr_pulse  output  NREGS  one-cycle pulse per register write.
REQ-016 SHALL have irq  output  1  registered interrupt, identical to bus_out irq field.

Function
REQ-017 Decode SHALL compare {bus_addr[high:2],2'd0} against each register address; non-matching addresses produce no ack and all-zero bus_out data.
REQ-018 rd_ack and wr_ack SHALL assert exactly one cycle after the cycle rd_req/wr_req is sampled with a matching address; rd_data SHALL be valid only in that ack cycle, else zero.
REQ-019 rd_pulse[i]/wr_pulse[i] SHALL assert in the same cycle as the corresponding ack.
REQ-020 RW register: write loads bus_wr_data[DATAWIDTH-1:0] on the request cycle edge; read returns value before any same-cycle write.
REQ-021 RO register: read returns in[i] sampled at the request cycle edge; write SHALL be acked and ignored.
REQ-022 W1C register: each cycle reg <= (reg & ~clr) | set[i], clr = write data on a write to i else 0; set SHALL win over clear on the same bit same cycle.
REQ-023 IRQ-enable register: NREGS bits RW, read zero-extended; bits for non-W1C registers SHALL read 0 and be ignored.
REQ-024 irq SHALL be registered: next irq = OR over i of (W1C_MASK[i] & irq_en[i] & |reg[i]); one-cycle latency from status/enable change.
REQ-025 Simultaneous rd_req and wr_req to the same address SHALL both ack in the same following cycle; read data is pre-write value.
REQ-026 Back-to-back requests every cycle SHALL each ack one cycle later, no stall.

Reset
REQ-027 On bus_reset_l low, asynchronously: RW registers=IZ, W1C registers=0, irq_en=0, rd_ack=wr_ack=0, rd_pulse=wr_pulse=0, irq=0.
REQ-028 A request in flight when reset asserts SHALL be dropped (no ack after release); set pulses during reset SHALL be ignored.
REQ-029 After release, the first request sampled on a clock edge SHALL be served normally.

Verification
REQ-030 NREGS=4, IZ=5: after reset, read reg0 -> rd_ack one cycle later, data 5, rd_pulse[0]=1.
REQ-031 Write 0xA5A5 to BUS_ADDR+8 (RW) -> wr_ack and wr_pulse[2] next cycle; out slice 2=0xA5A5; read-back 0xA5A5.
REQ-032 RO_MASK=0b0010, in[1]=0x1234: write 0xFFFF then read reg1 -> write acked, read data 0x1234.
REQ-033 W1C_MASK=0b1000, irq_en=0b1000: pulse set[3]=0x3 -> irq=1 one cycle later; write 0x1 -> reg3=0x2, irq=1; write 0x2 with set[3]=0x2 same cycle -> reg3=0x2 (set wins).
REQ-034 Request to BUS_ADDR+4*(NREGS+1) -> no ack, bus_out data 0; rd_req to reg0 then bus_reset_l low before ack -> no ack, all outputs at reset values.
